// File: rtl/cpu_run_ctrl.sv
// Run-mode controller: turns mode switches, a debounced step button and divided clock
// levels into a single-cycle CPU clock enable, with break handling and an issue counter.
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk100MHz,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             slow_clk,
  input  logic             fast_clk,
  input  logic             cpu_halt,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StStop = 2'b00;
  localparam logic [1:0] StRun  = 2'b01;
  localparam logic [1:0] StBrk  = 2'b10;

  localparam logic [1:0] ModeHalt = 2'b00;
  localparam logic [1:0] ModeStep = 2'b01;

  // Synchronizers
  logic [1:0] mode_m_q, mode_s_q;
  logic       btn_m_q, btn_s_q;

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      mode_m_q <= 2'b00;
      mode_s_q <= 2'b00;
      btn_m_q  <= 1'b0;
      btn_s_q  <= 1'b0;
    end else begin
      mode_m_q <= mode;
      mode_s_q <= mode_m_q;
      btn_m_q  <= step_btn;
      btn_s_q  <= btn_m_q;
    end
  end

  // Debounce
  logic           btn_db_q, btn_db_d;
  logic           btn_db_prev_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           step_pulse;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DbMax) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

  assign step_pulse = btn_db_q & ~btn_db_prev_q;

  // Clock-level edge detect; held high in reset so a high level at release is not a tick
  logic slow_q, fast_q;
  logic slow_tick, fast_tick;

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      slow_q <= 1'b1;
      fast_q <= 1'b1;
    end else begin
      slow_q <= slow_clk;
      fast_q <= fast_clk;
    end
  end

  assign slow_tick = slow_clk & ~slow_q;
  assign fast_tick = fast_clk & ~fast_q;

  // Run FSM, enable and issue counter
  logic [1:0]       state_q, state_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_clr;

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      StStop: begin
        if (cpu_halt) begin
          state_d = StBrk;
        end else if (mode_s_q[1]) begin
          state_d = StRun;
        end else if (mode_s_q == ModeStep) begin
          ce_d = step_pulse;
        end
      end
      StRun: begin
        // A tick coinciding with leaving RUN is dropped
        if (cpu_halt) begin
          state_d = StBrk;
        end else if (!mode_s_q[1]) begin
          state_d = StStop;
        end else begin
          ce_d = mode_s_q[0] ? fast_tick : slow_tick;
        end
      end
      StBrk: begin
        // Only an explicit pass through HALT releases a break
        if (!cpu_halt && (mode_s_q == ModeHalt)) begin
          state_d = StStop;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = StStop;
      end
    endcase
  end

  always_comb begin
    if (cnt_clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(ce_d);
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state_q <= StStop;
      ce_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_ce    = ce_q;
  assign state     = state_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus a randomized run against
// a cycle-level behavioural model of the run/stop/break rules.
module tb_cpu_run_ctrl;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned CntW      = 4;

  localparam logic [1:0] MsStop = 2'b00;
  localparam logic [1:0] MsRun  = 2'b01;
  localparam logic [1:0] MsBrk  = 2'b10;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mode;
  logic            step_btn;
  logic            slow_clk;
  logic            fast_clk;
  logic            cpu_halt;
  logic            cpu_ce;
  logic [1:0]      state;
  logic [CntW-1:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(DebCycles),
    .CNT_W          (CntW)
  ) dut (
    .clk100MHz(clk),
    .rst      (rst),
    .mode     (mode),
    .step_btn (step_btn),
    .slow_clk (slow_clk),
    .fast_clk (fast_clk),
    .cpu_halt (cpu_halt),
    .cpu_ce   (cpu_ce),
    .state    (state),
    .cycle_cnt(cycle_cnt)
  );

  // Behavioural model: mode is seen two edges late, ticks are rising levels, halt wins.
  logic [1:0] m_mh0, m_mh1;
  logic       m_ps, m_pf;
  logic [1:0] m_state, m_nstate;
  logic       m_ce, m_nce, m_clr;
  int         m_cnt;

  always_comb begin
    m_nstate = m_state;
    m_nce    = 1'b0;
    m_clr    = 1'b0;
    if (m_state == MsBrk) begin
      if (!cpu_halt && m_mh1 == 2'b00) begin
        m_nstate = MsStop;
        m_clr    = 1'b1;
      end
    end else if (cpu_halt) begin
      m_nstate = MsBrk;
    end else if (m_state == MsStop) begin
      if (m_mh1 >= 2'b10) m_nstate = MsRun;
    end else if (m_mh1 < 2'b10) begin
      m_nstate = MsStop;
    end else if (m_mh1 == 2'b11) begin
      m_nce = fast_clk && !m_pf;
    end else begin
      m_nce = slow_clk && !m_ps;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mh0   <= 2'b00;
      m_mh1   <= 2'b00;
      m_ps    <= 1'b1;
      m_pf    <= 1'b1;
      m_state <= MsStop;
      m_ce    <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_mh0   <= mode;
      m_mh1   <= m_mh0;
      m_ps    <= slow_clk;
      m_pf    <= fast_clk;
      m_state <= m_nstate;
      m_ce    <= m_nce;
      m_cnt   <= m_clr ? 0 : (m_cnt + int'(m_nce)) % 16;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; step_btn = 1'b0;
    slow_clk = 1'b1; fast_clk = 1'b1; cpu_halt = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cpu_ce !== 1'b0 || state !== 2'b00 || cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_async: ce=%b state=%b cnt=%0d want 0/00/0", cpu_ce, state, cycle_cnt);
    end
    repeat (3) cyc();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (cpu_ce !== 1'b0 || state !== 2'b00 || cycle_cnt !== 4'd0) begin
        failures++;
        $display("FAIL reset_release c%0d: ce=%b state=%b cnt=%0d want 0/00/0",
                 i, cpu_ce, state, cycle_cnt);
      end
    end
  endtask

  task automatic test_fast_run();
    logic prev, f, want;
    int   pulses;
    fast_clk = 1'b0;
    mode = 2'b11;
    cyc(); cyc();
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL fast_state_early: state=%b want 00", state);
    end
    cyc();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL fast_state_run: state=%b want 01", state);
    end
    prev   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      f = ((i / 5) % 2) == 1;
      fast_clk = f;
      cyc();
      want = f & ~prev;
      checks++;
      if (cpu_ce !== want) begin
        failures++;
        $display("FAIL fast_ce c%0d: got %b want %b", i, cpu_ce, want);
      end
      if (cpu_ce === 1'b1) pulses++;
      prev = f;
    end
    checks++;
    if (pulses != 10) begin
      failures++;
      $display("FAIL fast_pulses: got %0d want 10", pulses);
    end
    checks++;
    if (cycle_cnt !== 4'd10) begin
      failures++;
      $display("FAIL fast_cnt: got %0d want 10", cycle_cnt);
    end
  endtask

  task automatic test_step_bounce();
    logic [4:0] bounce;
    mode = 2'b01;
    repeat (4) cyc();
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL step_state: state=%b want 00", state);
    end
    bounce = 5'b10101;
    for (int k = 4; k >= 1; k--) begin
      step_btn = bounce[k];
      cyc();
      checks++;
      if (cpu_ce !== 1'b0) begin
        failures++;
        $display("FAIL step_bounce_ce b%0d: got %b want 0", k, cpu_ce);
      end
    end
    step_btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      checks++;
      if (cpu_ce !== (j == 7)) begin
        failures++;
        $display("FAIL step_ce j%0d: got %b want %b", j, cpu_ce, (j == 7));
      end
    end
    checks++;
    if (cycle_cnt !== 4'd11) begin
      failures++;
      $display("FAIL step_cnt: got %0d want 11", cycle_cnt);
    end
    step_btn = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      checks++;
      if (cpu_ce !== 1'b0) begin
        failures++;
        $display("FAIL step_release_ce j%0d: got %b want 0", j, cpu_ce);
      end
    end
  endtask

  task automatic test_halt_collision();
    mode = 2'b10;
    slow_clk = 1'b0;
    repeat (4) cyc();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL halt_pre_run: state=%b want 01", state);
    end
    slow_clk = 1'b1;
    cpu_halt = 1'b1;
    cyc();
    checks++;
    if (cpu_ce !== 1'b0 || state !== 2'b10) begin
      failures++;
      $display("FAIL halt_collide: ce=%b state=%b want 0/10", cpu_ce, state);
    end
    cpu_halt = 1'b0;
    slow_clk = 1'b0;
    cyc();
    slow_clk = 1'b1;
    cyc(); cyc();
    checks++;
    if (cpu_ce !== 1'b0 || state !== 2'b10) begin
      failures++;
      $display("FAIL halt_brk_hold: ce=%b state=%b want 0/10", cpu_ce, state);
    end
    mode = 2'b00;
    cyc(); cyc();
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL halt_brk_early: state=%b want 10", state);
    end
    cyc();
    checks++;
    if (state !== 2'b00 || cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL halt_to_stop: state=%b cnt=%0d want 00/0", state, cycle_cnt);
    end
    mode = 2'b10;
    repeat (3) cyc();
    checks++;
    if (state !== 2'b01 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL halt_rerun: state=%b ce=%b want 01/0", state, cpu_ce);
    end
  endtask

  task automatic test_counter_wrap();
    logic [CntW-1:0] want;
    mode = 2'b11;
    fast_clk = 1'b0;
    repeat (3) cyc();
    for (int p = 1; p <= 17; p++) begin
      fast_clk = 1'b1;
      cyc();
      checks++;
      if (cpu_ce !== 1'b1) begin
        failures++;
        $display("FAIL wrap_ce p%0d: got %b want 1", p, cpu_ce);
      end
      cyc();
      want = CntW'(p % 16);
      checks++;
      if (cpu_ce !== 1'b0 || cycle_cnt !== want) begin
        failures++;
        $display("FAIL wrap_cnt p%0d: ce=%b cnt=%0d want 0/%0d", p, cpu_ce, cycle_cnt, want);
      end
      fast_clk = 1'b0;
      cyc(); cyc();
    end
  endtask

  task automatic test_reset_mid_run();
    fast_clk = 1'b1;
    cyc();
    checks++;
    if (cpu_ce !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: ce=%b want 1", cpu_ce);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (cpu_ce !== 1'b0 || cycle_cnt !== 4'd0 || state !== 2'b00) begin
      failures++;
      $display("FAIL midrst_async: ce=%b cnt=%0d state=%b want 0/0/00",
               cpu_ce, cycle_cnt, state);
    end
    cyc();
    fast_clk = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_random();
    mode = 2'b00; cpu_halt = 1'b0; step_btn = 1'b0;
    slow_clk = 1'b1; fast_clk = 1'b1;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) slow_clk = ~slow_clk;
      if ($urandom_range(0, 2) == 0) fast_clk = ~fast_clk;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if (cpu_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0))
        cpu_halt = ~cpu_halt;
      cyc();
      checks++;
      if (cpu_ce !== m_ce || state !== m_state || cycle_cnt !== CntW'(m_cnt)) begin
        failures++;
        $display("FAIL random c%0d: ce=%b state=%b cnt=%0d want %b/%b/%0d",
                 n, cpu_ce, state, cycle_cnt, m_ce, m_state, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_run();
    test_step_bounce();
    test_halt_collision();
    test_counter_wrap();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
